serial_adder_ctrl: RTL and testbench

//   Bit-serial adder controller: sequences one full-adder bit cell (two half_adder

---
 rtl/serial_adder_pkg.sv | 9 +
 rtl/half_adder.sv | 10 +
 rtl/serial_adder_ctrl.sv | 119 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding and the legal WIDTH range.
package serial_adder_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;
endpackage

// File: rtl/half_adder.sv
// One-bit half adder; two of these plus an OR make the serial adder's full-adder bit cell.
module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic carry_o
);
  assign sum_o   = a_i ^ b_i;
  assign carry_o = a_i & b_i;
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell walked LSB-first over WIDTH RUN cycles, then a DONE pulse.
// Start is only accepted in IDLE; sum/cout stay stable until the next operation completes or reset.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_adder_ctrl: WIDTH out of range");
  end

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;

  logic ha0_sum, ha0_carry, bit_sum, ha1_carry, bit_carry;

  half_adder u_ha0 (
    .a_i     (a_sh_q[0]),
    .b_i     (b_sh_q[0]),
    .sum_o   (ha0_sum),
    .carry_o (ha0_carry)
  );

  half_adder u_ha1 (
    .a_i     (ha0_sum),
    .b_i     (c_q),
    .sum_o   (bit_sum),
    .carry_o (ha1_carry)
  );

  assign bit_carry = ha0_carry | ha1_carry;

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    cout_d   = cout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          c_d      = cin;
          cnt_d    = '0;
          sum_sh_d = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = {bit_sum, sum_sh_q[WIDTH-1:1]};
        c_d      = bit_carry;
        // Counter parks on the last bit instead of wrapping.
        if (cnt_q == CNT_LAST) begin
          sum_d   = {bit_sum, sum_sh_q[WIDTH-1:1]};
          cout_d  = bit_carry;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
      cout_q   <= cout_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: an 8-bit instance (directed + random) and a 2-bit one (exhaustive).
module tb_serial_adder_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, cin;
  logic [7:0] a, b;
  logic       busy, done, cout;
  logic [7:0] sum;
  logic       start2, cin2;
  logic [1:0] a2, b2;
  logic       busy2, done2, cout2;
  logic [1:0] sum2;

  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] sb8[$];
  logic [2:0] sb2[$];

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder_ctrl #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Operands are scrambled every cycle after acceptance; hold keeps start high until done.
  task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ic, input bit hold);
    int lat;
    bit acc, got;
    logic [8:0] e;
    a = ia; b = ib; cin = ic; start = 1'b1;
    sb8.push_back({1'b0, ia} + {1'b0, ib} + {8'd0, ic});
    lat = 0; acc = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      if (!acc && busy && !done) acc = 1;
      if (acc) begin
        lat++;
        if (!hold) start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      end
      if (done) begin
        got = 1;
        start = 1'b0;
      end
    end
    if (!got) begin
      chk("done8_timeout", 32'd0, 32'd1);
      void'(sb8.pop_front());
    end else begin
      e = sb8.pop_front();
      chk("sum8", {24'd0, sum}, {24'd0, e[7:0]});
      chk("cout8", {31'd0, cout}, {31'd0, e[8]});
      chk("lat8", lat, 32'd9);
    end
  endtask

  task automatic op2(input logic [1:0] ia, input logic [1:0] ib, input logic ic);
    int lat;
    bit acc, got;
    logic [2:0] e;
    a2 = ia; b2 = ib; cin2 = ic; start2 = 1'b1;
    sb2.push_back({1'b0, ia} + {1'b0, ib} + {2'd0, ic});
    lat = 0; acc = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (!acc && busy2 && !done2) acc = 1;
      if (acc) begin
        lat++;
        start2 = 1'b0;
        a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom);
      end
      if (done2) got = 1;
    end
    if (!got) begin
      chk("done2_timeout", 32'd0, 32'd1);
      void'(sb2.pop_front());
    end else begin
      e = sb2.pop_front();
      chk("res2", {29'd0, cout2, sum2}, {29'd0, e});
      chk("lat2", lat, 32'd3);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum", {24'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_res2", {29'd0, cout2, sum2}, 32'd0);
    rst_n = 1'b1;

    op8(8'hFF, 8'h01, 1'b0, 0);
    @(posedge clk); #1;
    chk("pulse_done", {31'd0, done}, 32'd0);
    chk("pulse_busy", {31'd0, busy}, 32'd0);

    op8(8'h5A, 8'hA5, 1'b1, 0);
    op8(8'h12, 8'h34, 1'b0, 0);

    op8(8'h3C, 8'hC3, 1'b0, 1);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("hold_idle_busy", {31'd0, busy}, 32'd0);
      chk("hold_idle_done", {31'd0, done}, 32'd0);
    end

    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("abort_run", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_nodone", {31'd0, done}, 32'd0);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_sum", {24'd0, sum}, 32'd0);
    chk("abort_cout", {31'd0, cout}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_after_done", {31'd0, done}, 32'd0);
    op8(8'h80, 8'h80, 1'b0, 0);

    for (int i = 0; i < 1000; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom), 0);

    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        for (int c = 0; c < 2; c++)
          op2(2'(x), 2'(y), 1'(c));

    chk("sb8_empty", sb8.size(), 32'd0);
    chk("sb2_empty", sb2.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
